// File: rtl/mul_arbiter_if.sv
// Bundle of request, multiplier and response signals shared by mul_arbiter and its environment.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mul_arbiter_if #(
  parameter int unsigned WIDTH = 64
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_ovf;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_prod;
  logic               rsp_ovf;
  logic               busy;
  logic [31:0]        ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_prod, mul_ovf, rsp_ready,
    output req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_ovf, busy,
           ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_prod, mul_ovf, rsp_ready,
    input  req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_ovf, busy,
           ops_done
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters; operands are held for
// MUL_LAT cycles, then product/overflow are captured and returned tagged with the requester id.
module mul_arbiter #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mul_arbiter_if.slave io_bus
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_lat_check
    $error("mul_arbiter: MUL_LAT must be within 1..15");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             r_state;
  logic               r_last_grant;
  logic [3:0]         r_lat_cnt;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [2*WIDTH-1:0] r_rsp_prod;
  logic               r_rsp_id;
  logic               r_rsp_ovf;
  logic               r_rsp_valid;
  logic [31:0]        r_ops_done;

  logic w_any_valid;
  logic w_grant_id;
  logic w_accept;

  // With both requesters valid, the one not granted last time wins.
  always_comb begin
    w_any_valid = io_bus.req0_valid | io_bus.req1_valid;
    w_grant_id  = (io_bus.req0_valid && io_bus.req1_valid) ? ~r_last_grant : io_bus.req1_valid;
    w_accept    = (r_state == StIdle) && !i_rst && w_any_valid;
  end

  assign io_bus.req0_ready = w_accept && !w_grant_id;
  assign io_bus.req1_ready = w_accept && w_grant_id;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_lat_cnt    <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_rsp_prod   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_mul_a      <= w_grant_id ? io_bus.req1_a : io_bus.req0_a;
            r_mul_b      <= w_grant_id ? io_bus.req1_b : io_bus.req0_b;
            r_rsp_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_lat_cnt    <= 4'(MUL_LAT);
            r_state      <= StBusy;
          end
        end
        StBusy: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          // Operands have been stable for MUL_LAT cycles at this edge.
          if (r_lat_cnt == 4'd1) begin
            r_rsp_prod  <= io_bus.mul_prod;
            r_rsp_ovf   <= io_bus.mul_ovf;
            r_rsp_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 32'd1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.mul_a     = r_mul_a;
  assign io_bus.mul_b     = r_mul_b;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_id    = r_rsp_id;
  assign io_bus.rsp_prod  = r_rsp_prod;
  assign io_bus.rsp_ovf   = r_rsp_ovf;
  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.ops_done  = r_ops_done;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: one instance with MUL_LAT=1, one with MUL_LAT=3,
// each driving a signed stub multiplier; expected responses go through scoreboard queues.
module tb_mul_arbiter;
  localparam int unsigned W = 64;

  typedef struct packed {
    logic         id;
    logic [127:0] prod;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst3;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb1[$];
  exp_t sb3[$];

  logic         r3_force;
  logic         r3_ovf;
  logic [127:0] r3_junk;

  mul_arbiter_if #(.WIDTH(W)) bus1 ();
  mul_arbiter_if #(.WIDTH(W)) bus3 ();

  mul_arbiter #(.WIDTH(W), .MUL_LAT(1)) dut1 (.i_clk(clk), .i_rst(rst1), .io_bus(bus1));
  mul_arbiter #(.WIDTH(W), .MUL_LAT(3)) dut3 (.i_clk(clk), .i_rst(rst3), .io_bus(bus3));

  function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    return sa * sb;
  endfunction

  assign bus1.mul_prod = smul(bus1.mul_a, bus1.mul_b);
  assign bus1.mul_ovf  = 1'b0;
  assign bus3.mul_prod = r3_force ? r3_junk : smul(bus3.mul_a, bus3.mul_b);
  assign bus3.mul_ovf  = r3_ovf;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic id, input logic [127:0] prod);
    exp_t e;
    e.id = id; e.prod = prod; e.ovf = 1'b0;
    sb1.push_back(e);
  endtask

  // Waits (bounded) for a response on bus1 and compares it against the scoreboard head.
  task automatic expect_rsp1(input string tag);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (bus1.rsp_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    check({tag, "_valid"}, bus1.rsp_valid, 1'b1);
    check({tag, "_sb_nonempty"}, sb1.size() != 0, 1'b1);
    if (sb1.size() != 0) begin
      e = sb1.pop_front();
      check({tag, "_id"}, bus1.rsp_id, e.id);
      check({tag, "_prod"}, bus1.rsp_prod, e.prod);
      check({tag, "_ovf"}, bus1.rsp_ovf, e.ovf);
    end
  endtask

  task automatic consume1();
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    #1;
  endtask

  // Presents an op on requester id of bus1, waits (bounded) for its ready, then drops valid.
  task automatic accept1(input string tag, input logic id, input logic [63:0] a,
                         input logic [63:0] b);
    int cyc;
    if (id) begin
      bus1.req1_a = a; bus1.req1_b = b; bus1.req1_valid = 1'b1;
    end else begin
      bus1.req0_a = a; bus1.req0_b = b; bus1.req0_valid = 1'b1;
    end
    #1;
    cyc = 0;
    while ((id ? bus1.req1_ready : bus1.req0_ready) !== 1'b1 && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    check({tag, "_ready"}, id ? bus1.req1_ready : bus1.req0_ready, 1'b1);
    @(negedge clk);
    if (id) bus1.req1_valid = 1'b0;
    else    bus1.req0_valid = 1'b0;
    #1;
  endtask

  task automatic reset1();
    rst1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   acc_n, rsp_n, last_acc, seen;
    logic gid;

    {bus1.req0_a, bus1.req0_b, bus1.req1_a, bus1.req1_b} = '0;
    {bus3.req0_a, bus3.req0_b, bus3.req1_a, bus3.req1_b} = '0;
    bus1.req1_valid = 1'b0; bus1.rsp_ready = 1'b0;
    bus3.req0_valid = 1'b0; bus3.req1_valid = 1'b0; bus3.rsp_ready = 1'b0;
    r3_force = 1'b0; r3_ovf = 1'b0; r3_junk = '0;
    bus1.req0_valid = 1'b1;
    rst1 = 1'b1;
    rst3 = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;

    // Reset state, with a requester already valid.
    check("rst_ready0", bus1.req0_ready, 1'b0);
    check("rst_busy", bus1.busy, 1'b0);
    check("rst_rsp_valid", bus1.rsp_valid, 1'b0);
    check("rst_ops_done", bus1.ops_done, 0);
    check("rst_mul_a", bus1.mul_a, 0);
    check("rst_rsp_prod", bus1.rsp_prod, 0);
    check("rst_rsp_id", bus1.rsp_id, 1'b0);

    // Test 1: single request, capture one edge after accept.
    bus1.req0_valid = 1'b0;
    rst1 = 1'b0;
    push1(1'b0, 128'd318090);
    accept1("t1", 1'b0, 64'd345, 64'd922);
    check("t1_busy", bus1.busy, 1'b1);
    check("t1_not_yet", bus1.rsp_valid, 1'b0);
    check("t1_mul_a", bus1.mul_a, 64'd345);
    @(negedge clk); #1;
    check("t1_lat", bus1.rsp_valid, 1'b1);
    expect_rsp1("t1");
    consume1();
    check("t1_ops_done", bus1.ops_done, 1);
    check("t1_idle", bus1.busy, 1'b0);

    // Test 2: simultaneous requests after reset; req0 wins the first tie.
    reset1();
    check("t2_ops_rst", bus1.ops_done, 0);
    bus1.req0_a = 64'd3;    bus1.req0_b = 64'd5;  bus1.req0_valid = 1'b1;
    bus1.req1_a = -64'd345; bus1.req1_b = 64'd22; bus1.req1_valid = 1'b1;
    #1;
    check("t2_grant0", bus1.req0_ready, 1'b1);
    check("t2_nogrant1", bus1.req1_ready, 1'b0);
    push1(1'b0, 128'd15);
    push1(1'b1, -128'd7590);
    @(negedge clk);
    bus1.req0_valid = 1'b0;
    #1;
    check("t2_busy_rdy0", bus1.req0_ready, 1'b0);
    check("t2_busy_rdy1", bus1.req1_ready, 1'b0);
    expect_rsp1("t2a");
    consume1();
    accept1("t2b_acc", 1'b1, -64'd345, 64'd22);
    expect_rsp1("t2b");
    consume1();
    check("t2_ops_done", bus1.ops_done, 2);

    // Test 3: response stalled; everything must hold and nothing may be accepted.
    push1(1'b0, 128'd63);
    accept1("t3_acc", 1'b0, 64'd7, 64'd9);
    expect_rsp1("t3");
    bus1.req0_valid = 1'b1;
    bus1.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("t3_hold_valid", bus1.rsp_valid, 1'b1);
      check("t3_hold_prod", bus1.rsp_prod, 128'd63);
      check("t3_hold_id", bus1.rsp_id, 1'b0);
      check("t3_hold_rdy", {bus1.req0_ready, bus1.req1_ready}, 2'b00);
      check("t3_hold_mul", {bus1.mul_a, bus1.mul_b}, {64'd7, 64'd9});
      check("t3_hold_ops", bus1.ops_done, 2);
    end
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    consume1();
    check("t3_ops_done", bus1.ops_done, 3);

    // Test 6: both requesters valid continuously for four ops.
    reset1();
    bus1.req0_a = 64'd2;  bus1.req0_b = 64'd3; bus1.req0_valid = 1'b1;
    bus1.req1_a = -64'd4; bus1.req1_b = 64'd5; bus1.req1_valid = 1'b1;
    bus1.rsp_ready = 1'b1;
    acc_n = 0; rsp_n = 0; last_acc = 0;
    for (int cyc = 0; cyc < 40 && rsp_n < 4; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (acc_n == 4) begin
        bus1.req0_valid = 1'b0;
        bus1.req1_valid = 1'b0;
      end
      #1;
      if (bus1.rsp_valid === 1'b1) begin
        check("t6_sb_nonempty", sb1.size() != 0, 1'b1);
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          check("t6_id", bus1.rsp_id, e.id);
          check("t6_prod", bus1.rsp_prod, e.prod);
        end
        rsp_n++;
      end
      if (acc_n < 4 && (bus1.req0_ready | bus1.req1_ready) === 1'b1) begin
        gid = acc_n[0];
        check("t6_grant", {bus1.req1_ready, bus1.req0_ready}, gid ? 2'b10 : 2'b01);
        if (acc_n > 0) check("t6_spacing", cyc - last_acc, 3);
        push1(gid, gid ? -128'd20 : 128'd6);
        last_acc = cyc;
        acc_n++;
      end
    end
    check("t6_accepts", acc_n, 4);
    check("t6_responses", rsp_n, 4);
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    #1;
    check("t6_ops_done", bus1.ops_done, 4);

    // Test 5 (MUL_LAT=3): garbage product until the capture edge, all-ones operands.
    rst3 = 1'b0;
    bus3.req0_a = '1; bus3.req0_b = '1; bus3.req0_valid = 1'b1;
    r3_ovf = 1'b1; r3_force = 1'b1; r3_junk = 128'hDEAD;
    e.id = 1'b0; e.prod = 128'd1; e.ovf = 1'b1;
    sb3.push_back(e);
    #1;
    check("t5_ready", bus3.req0_ready, 1'b1);
    @(negedge clk);
    bus3.req0_valid = 1'b0;
    r3_junk = 128'hBEEF;
    #1;
    check("t5_k1_valid", bus3.rsp_valid, 1'b0);
    check("t5_mul_a", bus3.mul_a, {64{1'b1}});
    @(negedge clk);
    r3_junk = 128'h1234;
    #1;
    check("t5_k2_valid", bus3.rsp_valid, 1'b0);
    @(negedge clk);
    r3_force = 1'b0;
    #1;
    check("t5_k3_pre", bus3.rsp_valid, 1'b0);
    @(negedge clk);
    r3_force = 1'b1;
    r3_junk = 128'h5555;
    #1;
    check("t5_capture", bus3.rsp_valid, 1'b1);
    check("t5_sb_nonempty", sb3.size() != 0, 1'b1);
    if (sb3.size() != 0) begin
      e = sb3.pop_front();
      check("t5_prod", bus3.rsp_prod, e.prod);
      check("t5_ovf", bus3.rsp_ovf, e.ovf);
      check("t5_id", bus3.rsp_id, e.id);
    end
    @(negedge clk); #1;
    check("t5_prod_held", bus3.rsp_prod, 128'd1);
    bus3.rsp_ready = 1'b1;
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    #1;
    check("t5_ops_done", bus3.ops_done, 1);

    // Test 4 (MUL_LAT=3): reset mid-BUSY aborts the op.
    bus3.req0_a = 64'd10; bus3.req0_b = 64'd10; bus3.req0_valid = 1'b1;
    #1;
    check("t4_ready", bus3.req0_ready, 1'b1);
    @(negedge clk);
    bus3.req0_valid = 1'b0;
    rst3 = 1'b1;
    #1;
    check("t4_busy_pre", bus3.busy, 1'b1);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("t4_busy", bus3.busy, 1'b0);
    check("t4_rsp_valid", bus3.rsp_valid, 1'b0);
    check("t4_ops_done", bus3.ops_done, 0);
    check("t4_mul_a", bus3.mul_a, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (bus3.rsp_valid === 1'b1 || bus3.busy === 1'b1) seen++;
    end
    check("t4_no_rsp", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
